// File: rtl/master_vol_pkg.sv
// Shared constants for the master volume stage.
//   GAIN_W     - width of the gain pot / gain register
//   UNITY_GAIN - gain code that passes samples through unchanged
//   IDLE/MUL_L/MUL_R/FIN - FSM state encoding
package master_vol_pkg;
  localparam int GAIN_W     = 12;
  localparam int UNITY_GAIN = 2048;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MUL_L = 2'd1;
  localparam logic [1:0] MUL_R = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;
endpackage

// File: rtl/master_vol_sat.sv
// Signed saturator: clamps an (isz+1)-bit two's complement value into osz bits.
//   din  in  isz+1  signed value to clamp
//   dout out osz    clamped signed value
module master_vol_sat #(
  parameter int isz = 17,
  parameter int osz = 16
) (
  input  logic [isz:0]   din,
  output logic [osz-1:0] dout
);
  // In range when every bit from the output sign bit upward matches the sign.
  logic in_range;

  always_comb begin
    in_range = (din[isz:osz-1] == '0) || (din[isz:osz-1] == '1);
    if (in_range)     dout = din[osz-1:0];
    else if (din[isz]) dout = {1'b1, {(osz-1){1'b0}}};
    else               dout = {1'b0, {(osz-1){1'b1}}};
  end
endmodule

// File: rtl/master_vol.sv
// Stereo master volume with slew-limited gain and mute.
// One multiplier is time-shared: left product, then right product, then
// both results are presented together with a one-cycle valid strobe.
//   clk       in   system clock
//   reset     in   synchronous active-low reset
//   in_l/in_r in   signed 16-bit sample pair, qualified by valid_in
//   valid_in  in   one-cycle strobe for in_l/in_r
//   pot       in   12-bit unsigned gain target
//   mute      in   forces gain target to 0
//   out_l/out_r out registered signed 16-bit outputs
//   valid     out  one-cycle strobe, outputs updated
//   gain      out  current slewed gain
module master_vol
  import master_vol_pkg::*;
#(
  parameter int STEP = 16,
  parameter int GSH  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [15:0]       in_l,
  input  logic signed [15:0]       in_r,
  input  logic                     valid_in,
  input  logic [GAIN_W-1:0]        pot,
  input  logic                     mute,
  output logic signed [15:0]       out_l,
  output logic signed [15:0]       out_r,
  output logic                     valid,
  output logic [GAIN_W-1:0]        gain
);
  localparam logic [GAIN_W-1:0] STEP_G = GAIN_W'(STEP);
  localparam logic [GAIN_W:0]   STEP_X = (GAIN_W+1)'(STEP);

  logic [1:0]               state_q, state_d;
  logic signed [15:0]       hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [GAIN_W-1:0]        gain_q, gain_d;
  logic signed [28:0]       prod_q, prod_d;
  logic signed [15:0]       sat_l_q, sat_l_d;
  logic signed [15:0]       out_l_q, out_l_d, out_r_q, out_r_d;
  logic                     valid_q, valid_d;

  logic [GAIN_W-1:0]        target, gain_nxt;
  logic [GAIN_W:0]          dlt;
  logic signed [15:0]       mul_a;
  logic signed [28:0]       a_ext, g_ext, mul_res;
  logic [17:0]              scaled;
  logic [15:0]              sat_out;

  // Slew toward target; step is clamped to the remaining distance so the
  // gain lands exactly on target and never wraps.
  always_comb begin
    target   = mute ? '0 : pot;
    dlt      = '0;
    gain_nxt = gain_q;
    if (target >= gain_q) begin
      dlt      = {1'b0, target} - {1'b0, gain_q};
      gain_nxt = (dlt <= STEP_X) ? target : gain_q + STEP_G;
    end else begin
      dlt      = {1'b0, gain_q} - {1'b0, target};
      gain_nxt = (dlt <= STEP_X) ? target : gain_q - STEP_G;
    end
  end

  // Shared multiplier: gain is treated as a non-negative 13-bit signed value.
  always_comb begin
    mul_a   = (state_q == MUL_L) ? hold_l_q : hold_r_q;
    a_ext   = {{13{mul_a[15]}}, mul_a};
    g_ext   = {17'd0, gain_q};
    mul_res = a_ext * g_ext;
  end

  // Arithmetic shift floors toward -inf; 18 bits cover the full product range.
  assign scaled = 18'(prod_q >>> GSH);

  master_vol_sat #(.isz(17), .osz(16)) u_sat (
    .din  (scaled),
    .dout (sat_out)
  );

  always_comb begin
    state_d  = state_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    gain_d   = gain_q;
    prod_d   = prod_q;
    sat_l_d  = sat_l_q;
    out_l_d  = out_l_q;
    out_r_d  = out_r_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          hold_l_d = in_l;
          hold_r_d = in_r;
          gain_d   = gain_nxt;
          state_d  = MUL_L;
        end
      end
      MUL_L: begin
        prod_d  = mul_res;
        state_d = MUL_R;
      end
      MUL_R: begin
        sat_l_d = sat_out;
        prod_d  = mul_res;
        state_d = FIN;
      end
      default: begin
        out_l_d = sat_l_q;
        out_r_d = sat_out;
        valid_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      hold_l_q <= '0;
      hold_r_q <= '0;
      gain_q   <= '0;
      prod_q   <= '0;
      sat_l_q  <= '0;
      out_l_q  <= '0;
      out_r_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      gain_q   <= gain_d;
      prod_q   <= prod_d;
      sat_l_q  <= sat_l_d;
      out_l_q  <= out_l_d;
      out_r_q  <= out_r_d;
      valid_q  <= valid_d;
    end
  end

  assign out_l = out_l_q;
  assign out_r = out_r_q;
  assign valid = valid_q;
  assign gain  = gain_q;
endmodule
